// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_multiplier_twos_abs.sv
// Operand magnitude and sign extraction for signed/unsigned capture.
module twos_abs #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  // The most-negative value maps onto itself, which reads correctly as unsigned.
  assign sign = is_signed & x[WIDTH-1];
  assign mag  = sign ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one clock per multiplier bit.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_w(WIDTH);

  mul_state_t         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .x         (a),
    .is_signed (is_signed),
    .mag       (a_mag),
    .sign      (a_neg)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .x         (b),
    .is_signed (is_signed),
    .mag       (b_mag),
    .sign      (b_neg)
  );

  // Carry out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) begin
      sum = sum + {1'b0, mcand};
    end
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            product <= neg ? -acc_nxt : acc_nxt;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic       clk;
  logic       rst_n;

  logic       st4;
  logic       is4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [7:0] p4;

  logic        st8;
  logic        is8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  int nvec;
  int nfail;

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t tbl [8];

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (st4),
    .is_signed (is4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .product   (p4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (st8),
    .is_signed (is8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .product   (p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run4(input string nm, input logic s,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp);
    int cyc;
    int bc;
    @(negedge clk);
    is4 = s;
    a4  = a;
    b4  = b;
    st4 = 1'b1;
    @(posedge clk);
    #1;
    st4 = 1'b0;
    chk({nm, " busy_rise"}, 64'(busy4), 64'd1);
    bc  = busy4 ? 1 : 0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy4) bc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd4);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd4);
    chk({nm, " product"}, 64'(p4), 64'(exp));
    @(posedge clk);
    #1;
    chk({nm, " done_width"}, 64'(done4), 64'd0);
  endtask

  task automatic run8(input string nm, input logic s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int cyc;
    @(negedge clk);
    is8 = s;
    a8  = a;
    b8  = b;
    st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd8);
    chk({nm, " product"}, 64'(p8), 64'(exp));
    @(posedge clk);
    #1;
    chk({nm, " done_width"}, 64'(done8), 64'd0);
  endtask

  initial begin
    int nd;
    int bad;
    int cyc;
    int t [3];
    logic [7:0] prev;
    logic [7:0] pexp [3];

    nvec  = 0;
    nfail = 0;
    rst_n = 1'b0;
    st4 = 1'b0; is4 = 1'b0; a4 = '0; b4 = '0;
    st8 = 1'b0; is8 = 1'b0; a8 = '0; b8 = '0;

    tbl[0] = '{1'b0, 4'b1101, 4'b1010, 8'b10000010};
    tbl[1] = '{1'b0, 4'b1000, 4'b0010, 8'b00010000};
    tbl[2] = '{1'b0, 4'b1001, 4'b0011, 8'b00011011};
    tbl[3] = '{1'b0, 4'b1111, 4'b0011, 8'b00101101};
    tbl[4] = '{1'b1, 4'b1101, 4'b1010, 8'b00010010};
    tbl[5] = '{1'b1, 4'b1000, 4'b0010, 8'b11110000};
    tbl[6] = '{1'b1, 4'b1000, 4'b1000, 8'b01000000};
    tbl[7] = '{1'b1, 4'b0111, 4'b1111, 8'b11111001};

    #12;
    chk("reset busy", 64'(busy4), 64'd0);
    chk("reset done", 64'(done4), 64'd0);
    chk("reset product", 64'(p4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run4($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].p);
    end

    // start pulse during CALC with different operands
    @(negedge clk);
    is4 = 1'b0; a4 = 4'b1101; b4 = 4'b1010; st4 = 1'b1;
    @(posedge clk);
    #1;
    st4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a4 = 4'b0111; b4 = 4'b0111; st4 = 1'b1;
    @(posedge clk);
    #1;
    st4 = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        nd++;
        chk("ignore_start product", 64'(p4), 64'd130);
      end
      @(posedge clk);
      #1;
    end
    chk("ignore_start done_count", 64'(nd), 64'd1);
    chk("ignore_start idle", 64'(busy4), 64'd0);

    // asynchronous reset between edges mid-CALC
    @(negedge clk);
    is4 = 1'b1; a4 = 4'b0111; b4 = 4'b0011; st4 = 1'b1;
    @(posedge clk);
    #1;
    st4 = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst busy", 64'(busy4), 64'd0);
    chk("async_rst done", 64'(done4), 64'd0);
    chk("async_rst product", 64'(p4), 64'd0);
    #2;
    rst_n = 1'b1;
    run4("post_rst", 1'b0, 4'b0101, 4'b0011, 8'b00001111);

    // start held high: back-to-back operations
    pexp[0] = 8'd35;
    pexp[1] = 8'd5;
    pexp[2] = 8'd10;
    @(negedge clk);
    is4 = 1'b0; a4 = 4'd7; b4 = 4'd5; st4 = 1'b1;
    nd = 0; bad = 0; cyc = 0;
    prev = p4;
    while (nd < 3 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done4) begin
        t[nd] = cyc;
        chk($sformatf("held op%0d product", nd), 64'(p4), 64'(pexp[nd]));
        nd++;
        a4 = (nd == 1) ? 4'd1 : 4'd2;
      end else if (p4 !== prev) begin
        bad++;
      end
      prev = p4;
    end
    st4 = 1'b0;
    chk("held done_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("held period1", 64'(t[1] - t[0]), 64'd6);
      chk("held period2", 64'(t[2] - t[1]), 64'd6);
    end
    chk("held product_stable", 64'(bad), 64'd0);
    repeat (3) @(posedge clk);

    run8("w8 unsigned", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("w8 signed", 1'b1, 8'h80, 8'h7F, 16'hC080);
    run8("w8 signed_minmin", 1'b1, 8'h80, 8'h80, 16'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
